// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync remote RF control path.
package fractal_sync_pkg;

    // Number of check ports exposed by one remote RF instance.
    localparam int unsigned RF_N_PORTS = 2;

    // Coded result returned to a requester.
    typedef enum logic [1:0] {
        RSP_STORED,
        RSP_HIT,
        RSP_BYPASS,
        RSP_ERR
    } rf_rsp_e;

    // Per-port sequencing state.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } rf_ctrl_state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// past the winner whenever the grant is consumed.
module fractal_sync_rr_arb
    import fractal_sync_pkg::*;
#(
    parameter  int unsigned N_REQ     = 2,
    localparam int unsigned IDX_WIDTH = idx_width(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req,
    input  logic                 advance,
    output logic [N_REQ-1:0]     gnt_onehot,
    output logic [IDX_WIDTH-1:0] gnt_idx
);

    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH:0]   cand;
    logic                 found;

    // Cyclic scan from the pointer; the first asserted request wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_WIDTH+1)'(i);
            if (cand >= (IDX_WIDTH+1)'(N_REQ))
                cand = cand - (IDX_WIDTH+1)'(N_REQ);
            if (!found && req[cand[IDX_WIDTH-1:0]]) begin
                found                           = 1'b1;
                gnt_onehot[cand[IDX_WIDTH-1:0]] = 1'b1;
                gnt_idx                         = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ptr_q <= '0;
        else if (advance)
            ptr_q <= (gnt_idx == IDX_WIDTH'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/fractal_sync_remote_rf_ctrl.sv
// Arbitrates requesters onto the two remote RF check ports, issues a one-cycle
// check, and returns a coded response to the winning requester.
module fractal_sync_remote_rf_ctrl
    import fractal_sync_pkg::*;
#(
    parameter  int unsigned LEVEL_WIDTH = 1,
    parameter  int unsigned ID_WIDTH    = 1,
    parameter  int unsigned N_REQ       = 2,
    localparam int unsigned N_PORTS     = RF_N_PORTS,
    localparam int unsigned IDX_WIDTH   = idx_width(N_REQ)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [N_PORTS-1:0][N_REQ-1:0]                 req_valid_i,
    output logic [N_PORTS-1:0][N_REQ-1:0]                 req_ready_o,
    input  logic [N_PORTS-1:0][N_REQ-1:0][LEVEL_WIDTH-1:0] req_level_i,
    input  logic [N_PORTS-1:0][N_REQ-1:0][ID_WIDTH-1:0]   req_id_i,
    output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]           rf_level_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]              rf_id_o,
    output logic [N_PORTS-1:0]                            rf_check_o,
    input  logic [N_PORTS-1:0]                            rf_present_i,
    input  logic [N_PORTS-1:0]                            rf_sig_err_i,
    input  logic                                          rf_bypass_i,
    output logic [N_PORTS-1:0]                            rsp_valid_o,
    input  logic [N_PORTS-1:0]                            rsp_ready_i,
    output logic [N_PORTS-1:0][IDX_WIDTH-1:0]             rsp_idx_o,
    output rf_rsp_e [N_PORTS-1:0]                         rsp_code_o
);

    rf_ctrl_state_e                        state_q [N_PORTS];
    logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]   level_q;
    logic [N_PORTS-1:0][ID_WIDTH-1:0]      id_q;
    logic [N_PORTS-1:0][IDX_WIDTH-1:0]     idx_q;

    logic [N_PORTS-1:0][N_REQ-1:0]         gnt_onehot;
    logic [N_PORTS-1:0][IDX_WIDTH-1:0]     gnt_idx;
    logic [N_PORTS-1:0]                    accept;
    logic [N_PORTS-1:0]                    in_issue;
    logic                                  both_issue;
    rf_rsp_e [N_PORTS-1:0]                 next_code;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        fractal_sync_rr_arb #(
            .N_REQ (N_REQ)
        ) i_arb (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req        (req_valid_i[p]),
            .advance    (accept[p]),
            .gnt_onehot (gnt_onehot[p]),
            .gnt_idx    (gnt_idx[p])
        );
    end

    // Grant only in IDLE, and never while reset is held.
    always_comb begin
        accept      = '0;
        req_ready_o = '0;
        in_issue    = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            accept[p]   = rst_ni && (state_q[p] == IDLE) && (|req_valid_i[p]);
            in_issue[p] = (state_q[p] == ISSUE);
            if (accept[p])
                req_ready_o[p] = gnt_onehot[p];
        end
        both_issue = &in_issue;
    end

    // Response code: signature error dominates, then a qualified bypass, then presence.
    always_comb begin
        next_code = '{default: RSP_STORED};
        for (int p = 0; p < N_PORTS; p++) begin
            if (rf_sig_err_i[p])
                next_code[p] = RSP_ERR;
            else if (both_issue && rf_bypass_i)
                next_code[p] = RSP_BYPASS;
            else if (rf_present_i[p])
                next_code[p] = RSP_HIT;
            else
                next_code[p] = RSP_STORED;
        end
    end

    // RF drive: an idle port mirrors the busy port's level with a flipped id so the
    // RF can never see two equal signatures and raise a spurious bypass.
    always_comb begin
        rf_level_o = '0;
        rf_id_o    = '0;
        rf_check_o = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (in_issue[p]) begin
                rf_level_o[p] = level_q[p];
                rf_id_o[p]    = id_q[p];
                rf_check_o[p] = 1'b1;
            end
        end
        if (in_issue[0] && !in_issue[1]) begin
            rf_level_o[1] = level_q[0];
            rf_id_o[1]    = id_q[0] ^ ID_WIDTH'(1);
        end else if (in_issue[1] && !in_issue[0]) begin
            rf_level_o[0] = level_q[1];
            rf_id_o[0]    = id_q[1] ^ ID_WIDTH'(1);
        end
    end

    // Per-port IDLE -> ISSUE -> RESP sequencer with registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < N_PORTS; p++) begin
                state_q[p]    <= IDLE;
                rsp_code_o[p] <= RSP_STORED;
            end
            level_q     <= '0;
            id_q        <= '0;
            idx_q       <= '0;
            rsp_valid_o <= '0;
            rsp_idx_o   <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                case (state_q[p])
                    IDLE: begin
                        if (accept[p]) begin
                            level_q[p] <= req_level_i[p][gnt_idx[p]];
                            id_q[p]    <= req_id_i[p][gnt_idx[p]];
                            idx_q[p]   <= gnt_idx[p];
                            state_q[p] <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        rsp_code_o[p]  <= next_code[p];
                        rsp_idx_o[p]   <= idx_q[p];
                        rsp_valid_o[p] <= 1'b1;
                        state_q[p]     <= RESP;
                    end
                    RESP: begin
                        if (rsp_ready_i[p]) begin
                            rsp_valid_o[p] <= 1'b0;
                            state_q[p]     <= IDLE;
                        end
                    end
                    default: state_q[p] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fractal_sync_remote_rf_ctrl.sv
// Scoreboard bench for fractal_sync_remote_rf_ctrl: expected responses are
// queued at grant time and compared when each response is accepted.
module tb_fractal_sync_remote_rf_ctrl;
    import fractal_sync_pkg::*;

    localparam int LW = 1;
    localparam int IW = 1;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0][NR-1:0]         req_valid;
    logic [1:0][NR-1:0]         req_ready;
    logic [1:0][NR-1:0][LW-1:0] req_level;
    logic [1:0][NR-1:0][IW-1:0] req_id;
    logic [1:0][LW-1:0]         rf_level;
    logic [1:0][IW-1:0]         rf_id;
    logic [1:0]                 rf_check;
    logic [1:0]                 present;
    logic [1:0]                 sig_err;
    logic                       bypass;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0][0:0]            rsp_idx;
    logic [1:0][1:0]            rsp_code;

    fractal_sync_remote_rf_ctrl #(
        .LEVEL_WIDTH (LW),
        .ID_WIDTH    (IW),
        .N_REQ       (NR)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_level_i  (req_level),
        .req_id_i     (req_id),
        .rf_level_o   (rf_level),
        .rf_id_o      (rf_id),
        .rf_check_o   (rf_check),
        .rf_present_i (present),
        .rf_sig_err_i (sig_err),
        .rf_bypass_i  (bypass),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_idx_o    (rsp_idx),
        .rsp_code_o   (rsp_code)
    );

    typedef struct packed {
        logic       idx;
        logic [1:0] code;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rr_m[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int p, input logic idx, input logic [1:0] code);
        exp_t e;
        e.idx  = idx;
        e.code = code;
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic pop_cmp(input int p);
        exp_t e;
        int   sz;
        sz = (p == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
            check($sformatf("sb_underflow_p%0d", p), 32'd1, 32'd0);
        end else begin
            if (p == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("rsp_idx_p%0d", p), 32'(rsp_idx[p]), 32'(e.idx));
            check($sformatf("rsp_code_p%0d", p), 32'(rsp_code[p]), 32'(e.code));
        end
    endtask

    // Response monitor: every accepted response is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid[0] && rsp_ready[0]) pop_cmp(0);
            if (rsp_valid[1] && rsp_ready[1]) pop_cmp(1);
        end
    end

    task automatic send(input int p, input int r, input logic lvl, input logic id,
                        input logic [1:0] code);
        bit got = 1'b0;
        req_level[p][r] = lvl;
        req_id[p][r]    = id;
        req_valid[p][r] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p][r]) got = 1'b1;
        end
        check($sformatf("grant_p%0d_r%0d", p, r), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("onehot_p%0d", p), 32'(req_ready[p]), 32'(1 << r));
            push(p, r[0], code);
            rr_m[p] = (r + 1) % NR;
        end
        @(posedge clk); #1;
        req_valid[p][r] = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sb0.size() == 0 && sb1.size() == 0 && rsp_valid == 2'b00) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_level = '0;
        req_id    = '0;
        present   = '0;
        sig_err   = '0;
        bypass    = 1'b0;
        rsp_ready = 2'b11;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_check", 32'(rf_check), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_level_id", 32'({rf_level, rf_id}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single request, exact cycle timing and idle-port drive.
        req_valid[0][0] = 1'b1;
        @(negedge clk);
        check("t1_ready_c0", 32'(req_ready), 32'b0001);
        check("t1_no_check_c0", 32'(rf_check), 32'd0);
        push(0, 1'b0, RSP_STORED);
        rr_m[0] = 1;
        @(posedge clk); #1;
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        check("t1_check_c1", 32'(rf_check), 32'b01);
        check("t1_lvl0", 32'(rf_level[0]), 32'd0);
        check("t1_id0", 32'(rf_id[0]), 32'd0);
        check("t1_idle_lvl1", 32'(rf_level[1]), 32'd0);
        check("t1_idle_id1", 32'(rf_id[1]), 32'd1);
        check("t1_no_rsp_c1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rsp_c2", 32'(rsp_valid), 32'b01);
        check("t1_check_off_c2", 32'(rf_check), 32'd0);
        @(negedge clk);
        check("t1_rsp_done", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // 2a: both ports issue together with bypass asserted.
        bypass = 1'b1;
        fork
            send(0, 0, 1'b1, 1'b1, RSP_BYPASS);
            send(1, 0, 1'b1, 1'b1, RSP_BYPASS);
        join
        check("t2_both_check", 32'(rf_check), 32'b11);
        check("t2_both_lvl", 32'(rf_level), 32'b11);
        drain();

        // 2b: port1 one cycle late, bypass ignored, codes from presence.
        present = 2'b01;
        fork
            send(0, 0, 1'b1, 1'b1, RSP_HIT);
            begin
                @(posedge clk); #1;
                send(1, 0, 1'b1, 1'b1, RSP_STORED);
            end
        join
        drain();

        // 3: both port0 requesters held valid, grants follow the RR model.
        present = 2'b00;
        bypass  = 1'b0;
        req_level[0][0] = 1'b0; req_id[0][0] = 1'b0;
        req_level[0][1] = 1'b1; req_id[0][1] = 1'b1;
        req_valid[0]    = 2'b11;
        g = 0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            @(negedge clk);
            if (req_ready[0] != '0) begin
                check("t3_rr_gnt", 32'(req_ready[0]), 32'(1 << rr_m[0]));
                push(0, rr_m[0][0], RSP_STORED);
                rr_m[0] = (rr_m[0] + 1) % NR;
                g++;
            end
        end
        check("t3_gnt_count", 32'(g), 32'd4);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        drain();

        // 4: sig_err wins over presence and over a qualified bypass.
        sig_err = 2'b01;
        present = 2'b11;
        bypass  = 1'b1;
        fork
            send(0, 0, 1'b0, 1'b1, RSP_ERR);
            send(1, 1, 1'b0, 1'b1, RSP_BYPASS);
        join
        drain();
        sig_err = 2'b00;
        present = 2'b00;
        bypass  = 1'b0;

        // 5: port0 response stalled; port1 keeps cycling.
        rsp_ready[0] = 1'b0;
        send(0, 0, 1'b0, 1'b0, RSP_STORED);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("t5_rsp_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid[0][1] = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("t5_hold_valid", 32'(rsp_valid[0]), 32'd1);
                    check("t5_hold_idx", 32'(rsp_idx[0]), 32'd0);
                    check("t5_hold_code", 32'(rsp_code[0]), 32'(RSP_STORED));
                    check("t5_no_grant", 32'(req_ready[0]), 32'd0);
                end
            end
            begin
                send(1, 0, 1'b0, 1'b0, RSP_STORED);
                send(1, 1, 1'b1, 1'b0, RSP_STORED);
                send(1, 0, 1'b1, 1'b1, RSP_STORED);
            end
        join
        check("t5_p1_done", 32'(sb1.size()), 32'd0);
        check("t5_p0_pending", 32'(sb0.size()), 32'd1);
        req_valid[0][1] = 1'b0;
        rsp_ready[0]    = 1'b1;
        drain();

        // 6: reset while port0 is in ISSUE.
        req_valid[0][1] = 1'b1;
        @(negedge clk);
        check("t6_gnt_r1", 32'(req_ready[0]), 32'b10);
        @(posedge clk); #1;
        req_valid[0][1] = 1'b0;
        check("t6_in_issue", 32'(rf_check), 32'b01);
        rst_n = 1'b0;
        #1;
        check("t6_rst_check", 32'(rf_check), 32'd0);
        check("t6_rst_rsp", 32'(rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_rf", 32'({rf_level, rf_id}), 32'd0);
        check("t6_rst_rsp_fields", 32'({rsp_idx, rsp_code}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_m  = '{0, 0};
        @(posedge clk); #1;
        req_valid[0] = 2'b11;
        @(negedge clk);
        check("t6_first_gnt_r0", 32'(req_ready[0]), 32'b01);
        push(0, 1'b0, RSP_STORED);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
